qlf_k6n10f_pipe_addsub: RTL and testbench
=========================================

Name: qlf_k6n10f_pipe_addsub

Overview:
- Pipelined, carry-segmented adder/subtractor that consumes the per-segment `$alu` carry-chain mapping.
- Splits a WIDTH-bit add/sub into NSEG = WIDTH/SEG slices, one slice per pipeline stage, with the carry registered between stages. This keeps each carry chain short enough to close timing on k6n10f.
- Sits between operand producers and result consumers, using valid/ready handshakes on both sides.
- Full throughput: one operation per cycle.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of SEG.
- SEG, 8, bits per pipeline segment; must be > 2 so each slice maps to an adder_carry chain. NSEG = WIDTH/SEG >= 1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A (unsigned/two's complement).
- b  input  WIDTH  operand B.
- sub  input  1  1: compute a-b; 0: compute a+b.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (async assert, sync-safe deassert internally not required):
  - all stage valid bits, sum, cout, ovf, out_valid = 0.
  - in_ready = 1 after reset.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Global advance enable: en = !out_valid || out_ready. in_ready = en, combinational, no dependency on in_valid.
- When en = 0, every stage register holds, including data, carries and valid bits.
- When en = 1, all stages shift by one. Empty stages (bubbles) shift as invalid.
- Stage k (0..NSEG-1) computes slice [k*SEG +: SEG] = A_k + (B_k ^ {SEG{sub}}) + c_k:
  - c_0 = sub.
  - c_k = registered carry out of stage k-1.
- Input skew: slices above k are carried forward in pipeline registers alongside the transaction. Already-computed lower slices are carried forward as well, so result slices align at the output.
- The sub bit is captured at accept and travels with its transaction; it is not re-sampled.
- Latency: exactly NSEG cycles from input transfer to out_valid, with no stall. NSEG=1 gives 1 cycle (fully registered output).
- Throughput: 1 beat/cycle when out_ready is held high. No beat is dropped or duplicated, and ordering is strictly FIFO.
- cout = carry out of bit WIDTH-1 of the final stage.
- ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' = B ^ {WIDTH{sub}}.
- sum, cout and ovf are stable while out_valid && !out_ready.
- sum, cout and ovf are don't-care when out_valid = 0, but must not be X after reset.
- Simultaneous input and output transfer in the same cycle is allowed and sustains full throughput.
- Reset mid-operation discards all in-flight beats. After deassert, the first out_valid occurs only for beats accepted after reset.
- Illegal parameters (WIDTH % SEG != 0, or SEG <= 2): elaboration error.

Test Plan:
- Reset with WIDTH=32, SEG=8:
  - Stimulus: assert reset_n=0 with random inputs.
  - Required: out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 after release.
- Carry across segment boundaries:
  - Stimulus: a=0x000000FF, b=1, sub=0, out_ready=1.
  - Required: out_valid exactly 4 cycles later, sum=0x00000100, cout=0, ovf=0.
  - Stimulus: a=0xFFFFFFFF, b=1.
  - Required: sum=0, cout=1, ovf=0.
- Signed overflow:
  - a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, cout=0, ovf=1.
  - a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Subtraction:
  - a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
  - a=7, b=5, sub=1 -> sum=2, cout=1, ovf=0.
  - a=0, b=0, sub=1 -> sum=0, cout=1.
- Backpressure:
  - Stimulus: 16 back-to-back random beats while out_ready follows pattern 1,0,0,1,1,0...
  - Required: results match the model in order with none lost or duplicated; in_ready=0 exactly in cycles where out_valid && !out_ready; outputs stable while stalled.
- Reset mid-flight:
  - Stimulus: 3 beats in the pipe, then pulse reset_n low for 1 cycle.
  - Required: out_valid=0 immediately (async); no stale result emerges; a new beat (a=1, b=2) yields sum=3 after 4 cycles.

Source files
------------

// File: rtl/qlf_k6n10f_pipe_addsub.sv
// Pipelined add/sub that resolves one SEG-bit carry segment per stage, with the
// carry registered between stages so each adder_carry chain stays SEG bits long.
module qlf_k6n10f_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = WIDTH / SEG;
    localparam int LAST = NSEG - 1;

    generate
        if ((WIDTH % SEG) != 0 || SEG <= 2) begin : g_param_check
            $error("qlf_k6n10f_pipe_addsub: WIDTH must be a multiple of SEG and SEG must exceed 2");
        end
    endgenerate

    // One carry segment: {carry_out, slice_sum}.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           ci);
        return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
    endfunction

    logic             en;

    logic             vld_p [NSEG];
    logic [WIDTH-1:0] a_p   [NSEG];
    logic [WIDTH-1:0] bx_p  [NSEG];
    logic [WIDTH-1:0] res_p [NSEG];
    logic             c_p   [NSEG];

    logic             src_vld [NSEG];
    logic [WIDTH-1:0] src_a   [NSEG];
    logic [WIDTH-1:0] src_bx  [NSEG];
    logic [WIDTH-1:0] src_res [NSEG];
    logic             src_c   [NSEG];
    logic [SEG:0]     add_r   [NSEG];
    logic [WIDTH-1:0] nxt_res [NSEG];

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage inputs: stage 0 takes the operand beat (B pre-inverted for sub, sub as
    // carry-in), later stages take the previous stage's registers.
    always_comb begin
        src_vld[0] = in_valid;
        src_a[0]   = a;
        src_bx[0]  = b ^ {WIDTH{sub}};
        src_c[0]   = sub;
        src_res[0] = '0;
        for (int k = 1; k < NSEG; k++) begin
            src_vld[k] = vld_p[k-1];
            src_a[k]   = a_p[k-1];
            src_bx[k]  = bx_p[k-1];
            src_c[k]   = c_p[k-1];
            src_res[k] = res_p[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            add_r[k]   = seg_add(src_a[k][k*SEG +: SEG], src_bx[k][k*SEG +: SEG], src_c[k]);
            nxt_res[k] = src_res[k];
            nxt_res[k][k*SEG +: SEG] = add_r[k][SEG-1:0];
        end
    end

    // Stage registers: the whole pipe shifts together or holds together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NSEG; k++) begin
                vld_p[k] <= 1'b0;
                a_p[k]   <= '0;
                bx_p[k]  <= '0;
                res_p[k] <= '0;
                c_p[k]   <= 1'b0;
            end
        end else if (en) begin
            for (int k = 0; k < NSEG; k++) begin
                vld_p[k] <= src_vld[k];
                a_p[k]   <= src_a[k];
                bx_p[k]  <= src_bx[k];
                res_p[k] <= nxt_res[k];
                c_p[k]   <= add_r[k][SEG];
            end
        end
    end

    // Output stage; ovf derives from registered operands so it holds during stalls.
    assign out_valid = vld_p[LAST];
    assign sum       = res_p[LAST];
    assign cout      = c_p[LAST];
    assign ovf       = (a_p[LAST][WIDTH-1] == bx_p[LAST][WIDTH-1]) &&
                       (res_p[LAST][WIDTH-1] != a_p[LAST][WIDTH-1]);

endmodule

// File: tb/tb_qlf_k6n10f_pipe_addsub.sv
// Table-driven and scoreboard bench for qlf_k6n10f_pipe_addsub (WIDTH=32, SEG=8).
module tb_qlf_k6n10f_pipe_addsub;

    localparam int WIDTH = 32;
    localparam int SEG   = 8;
    localparam int NSEG  = WIDTH / SEG;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
        bit          lat;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;
    int    n_push = 0;
    int    n_pop  = 0;
    beat_t sbq[$];
    beat_t cur;
    beat_t mon_e;
    bit    bp_mode = 1'b0;
    int    bp_i    = 0;
    logic [5:0] bp_pat = 6'b011001;
    bit          stalled_prev = 1'b0;
    logic [31:0] held_sum;
    logic        held_cout;
    logic        held_ovf;
    vec_t        vecs[10];

    qlf_k6n10f_pipe_addsub #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic beat_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        beat_t       r;
        logic [31:0] yx;
        logic [32:0] t;
        yx     = y ^ {32{s}};
        t      = {1'b0, x} + {1'b0, yx} + {32'd0, s};
        r.a    = x;
        r.b    = y;
        r.sub  = s;
        r.sum  = t[31:0];
        r.cout = t[32];
        r.ovf  = (x[31] == yx[31]) && (t[31] != x[31]);
        r.cyc  = 0;
        r.lat  = 1'b0;
        return r;
    endfunction

    function automatic beat_t from_vec(input vec_t v);
        beat_t r;
        r.a    = v.a;
        r.b    = v.b;
        r.sub  = v.sub;
        r.sum  = v.sum;
        r.cout = v.cout;
        r.ovf  = v.ovf;
        r.cyc  = 0;
        r.lat  = 1'b1;
        return r;
    endfunction

    // Consumer backpressure: pattern 1,0,0,1,1,0 repeating when enabled.
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            out_ready = bp_pat[bp_i % 6];
            bp_i++;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor: transfers are decided by values stable at the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            sbq.delete();
            stalled_prev = 1'b0;
        end else begin
            check("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
            if (stalled_prev) begin
                check("stall_sum_stable", sum, held_sum);
                check("stall_cout_stable", cout, held_cout);
                check("stall_ovf_stable", ovf, held_ovf);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    n_pop++;
                    check("sum", sum, mon_e.sum);
                    check("cout", cout, mon_e.cout);
                    check("ovf", ovf, mon_e.ovf);
                    if (mon_e.lat) check("latency", cyc - mon_e.cyc, NSEG);
                end
            end
            stalled_prev = out_valid && !out_ready;
            held_sum     = sum;
            held_cout    = cout;
            held_ovf     = ovf;
            if (in_valid && in_ready) begin
                cur.cyc = cyc;
                sbq.push_back(cur);
                n_push++;
            end
        end
    end

    task automatic send(input beat_t e);
        int w;
        w        = 0;
        a        = e.a;
        b        = e.b;
        sub      = e.sub;
        cur      = e;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w        = 0;
        in_valid = 1'b0;
        while (sbq.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        check("drain_queue_empty", sbq.size(), 0);
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[4] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[5] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0};
        vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[7] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0};
        vecs[8] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[9] = '{32'h00010000, 32'h00000001, 1'b1, 32'h0000FFFF, 1'b1, 1'b0};

        // Reset with random inputs applied.
        reset_n  = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        sub      = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom);
            a        = $urandom;
            b        = $urandom;
            sub      = 1'($urandom);
        end
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
        check("reset_ovf", ovf, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("reset_in_ready", in_ready, 1);

        // Directed vectors, back to back with out_ready high.
        for (int i = 0; i < 10; i++) send(from_vec(vecs[i]));
        drain();

        // Backpressure with 16 back-to-back random beats.
        n_push  = 0;
        n_pop   = 0;
        bp_mode = 1'b1;
        for (int i = 0; i < 16; i++) send(model($urandom, $urandom, 1'($urandom)));
        drain();
        bp_mode = 1'b0;
        check("bp_pushed", n_push, 16);
        check("bp_popped", n_pop, 16);
        @(posedge clk);
        #1;

        // Reset while three beats are in flight, first one already at the output.
        for (int i = 0; i < 3; i++) send(model($urandom, $urandom, 1'($urandom)));
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("midreset_in_ready", in_ready, 1);
        n_pop = 0;
        begin
            beat_t nb;
            nb     = model(32'd1, 32'd2, 1'b0);
            nb.sum = 32'd3;
            nb.lat = 1'b1;
            send(nb);
        end
        drain();
        check("midreset_new_beat_popped", n_pop, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
